// File: rtl/mmu_mem_arbiter_if.sv
// mmu_mem_arbiter_if: bundles the IF/DT request-response ports and the memory-side port.
// The slave modport is the arbiter's view; the master modport is the view of everything around it.
interface mmu_mem_arbiter_if;
   logic        iIF_REQ;
   logic        oIF_LOCK;
   logic [1:0]  iIF_ORDER;
   logic        iIF_RW;
   logic [31:0] iIF_ADDR;
   logic [31:0] iIF_DATA;
   logic        oIF_REQ;
   logic        iIF_LOCK;
   logic [63:0] oIF_DATA;
   logic        iDT_REQ;
   logic        oDT_LOCK;
   logic [1:0]  iDT_ORDER;
   logic        iDT_RW;
   logic [31:0] iDT_ADDR;
   logic [31:0] iDT_DATA;
   logic        oDT_REQ;
   logic        iDT_LOCK;
   logic [63:0] oDT_DATA;
   logic        oMEMORY_REQ;
   logic        iMEMORY_LOCK;
   logic [1:0]  oMEMORY_ORDER;
   logic        oMEMORY_RW;
   logic [31:0] oMEMORY_ADDR;
   logic [31:0] oMEMORY_DATA;
   logic        iMEMORY_REQ;
   logic        oMEMORY_LOCK;
   logic [63:0] iMEMORY_DATA;
   modport slave (
      input  iIF_REQ, iIF_ORDER, iIF_RW, iIF_ADDR, iIF_DATA, iIF_LOCK,
      output oIF_LOCK, oIF_REQ, oIF_DATA,
      input  iDT_REQ, iDT_ORDER, iDT_RW, iDT_ADDR, iDT_DATA, iDT_LOCK,
      output oDT_LOCK, oDT_REQ, oDT_DATA,
      output oMEMORY_REQ, oMEMORY_ORDER, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_LOCK,
      input  iMEMORY_LOCK, iMEMORY_REQ, iMEMORY_DATA
   );
   modport master (
      output iIF_REQ, iIF_ORDER, iIF_RW, iIF_ADDR, iIF_DATA, iIF_LOCK,
      input  oIF_LOCK, oIF_REQ, oIF_DATA,
      output iDT_REQ, iDT_ORDER, iDT_RW, iDT_ADDR, iDT_DATA, iDT_LOCK,
      input  oDT_LOCK, oDT_REQ, oDT_DATA,
      input  oMEMORY_REQ, oMEMORY_ORDER, oMEMORY_RW, oMEMORY_ADDR, oMEMORY_DATA, oMEMORY_LOCK,
      output iMEMORY_LOCK, iMEMORY_REQ, iMEMORY_DATA
   );
endinterface

// File: rtl/mmu_mem_arbiter.sv
// mmu_mem_arbiter: round-robin merge of IF/DT MMU requests onto one memory port.
// An owner-tag FIFO steers in-order read responses back to the requesting side.
module mmu_mem_arbiter #(
   parameter int P_DEPTH   = 16,
   parameter int P_DEPTH_N = 4
) (
   input  logic iCLOCK,
   input  logic iRESET,
   input  logic iFLUSH,
   output logic oPROTOCOL_ERR,
   mmu_mem_arbiter_if.slave bus
);
   logic                 gnt_dt, gnt_if, full, empty, head;
   logic                 mreq, mlock, accept, push, rsp, pop;
   logic                 last_q, last_d, err_q, err_d;
   logic                 if_req_q, if_req_d, dt_req_q, dt_req_d;
   logic [63:0]          if_data_q, if_data_d, dt_data_q, dt_data_d;
   logic [P_DEPTH_N:0]   cnt_q, cnt_d;
   logic [P_DEPTH_N-1:0] wr_q, wr_d, rd_q, rd_d;
   logic                 owner_q [P_DEPTH];
   always_comb begin
      // last_q: 0=IF, 1=DT; on a tie the side that did not win last time goes
      gnt_dt = bus.iDT_REQ && (!bus.iIF_REQ || !last_q);
      gnt_if = bus.iIF_REQ && !gnt_dt;
      full   = cnt_q == (P_DEPTH_N+1)'(P_DEPTH);
      empty  = cnt_q == '0;
      head   = owner_q[rd_q];
      mreq   = (bus.iIF_REQ || bus.iDT_REQ) && !iFLUSH && !full;
      mlock  = !empty && (head ? bus.iDT_LOCK : bus.iIF_LOCK);
      accept = mreq && !bus.iMEMORY_LOCK;
      push   = accept && !(gnt_dt ? bus.iDT_RW : bus.iIF_RW);
      rsp    = bus.iMEMORY_REQ && !mlock;
      pop    = rsp && !empty;
      last_d = accept ? gnt_dt : last_q;
      cnt_d  = iFLUSH ? '0 : cnt_q + (P_DEPTH_N+1)'(push) - (P_DEPTH_N+1)'(pop);
      wr_d   = iFLUSH ? '0 : wr_q + P_DEPTH_N'(push);
      rd_d   = iFLUSH ? '0 : rd_q + P_DEPTH_N'(pop);
      err_d  = err_q || (rsp && empty && !iFLUSH);
      if_req_d  = iFLUSH ? 1'b0 : bus.iIF_LOCK ? if_req_q : pop && !head;
      dt_req_d  = iFLUSH ? 1'b0 : bus.iDT_LOCK ? dt_req_q : pop && head;
      if_data_d = iFLUSH ? '0 : (!bus.iIF_LOCK && pop && !head) ? bus.iMEMORY_DATA : if_data_q;
      dt_data_d = iFLUSH ? '0 : (!bus.iDT_LOCK && pop && head) ? bus.iMEMORY_DATA : dt_data_q;
   end
   always_ff @(posedge iCLOCK or posedge iRESET) begin
      if (iRESET) begin
         last_q    <= 1'b1;
         err_q     <= 1'b0;
         cnt_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         if_req_q  <= 1'b0;
         dt_req_q  <= 1'b0;
         if_data_q <= '0;
         dt_data_q <= '0;
      end else begin
         last_q    <= last_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
         wr_q      <= wr_d;
         rd_q      <= rd_d;
         if_req_q  <= if_req_d;
         dt_req_q  <= dt_req_d;
         if_data_q <= if_data_d;
         dt_data_q <= dt_data_d;
      end
   end
   always_ff @(posedge iCLOCK) begin
      if (push) owner_q[wr_q] <= gnt_dt;
   end
   assign bus.oMEMORY_REQ   = mreq;
   assign bus.oMEMORY_ORDER = gnt_dt ? bus.iDT_ORDER : bus.iIF_ORDER;
   assign bus.oMEMORY_RW    = gnt_dt ? bus.iDT_RW    : bus.iIF_RW;
   assign bus.oMEMORY_ADDR  = gnt_dt ? bus.iDT_ADDR  : bus.iIF_ADDR;
   assign bus.oMEMORY_DATA  = gnt_dt ? bus.iDT_DATA  : bus.iIF_DATA;
   assign bus.oMEMORY_LOCK  = mlock;
   assign bus.oIF_LOCK      = !gnt_if || bus.iMEMORY_LOCK || full || iFLUSH;
   assign bus.oDT_LOCK      = !gnt_dt || bus.iMEMORY_LOCK || full || iFLUSH;
   assign bus.oIF_REQ       = if_req_q;
   assign bus.oDT_REQ       = dt_req_q;
   assign bus.oIF_DATA      = if_data_q;
   assign bus.oDT_DATA      = dt_data_q;
   assign oPROTOCOL_ERR     = err_q;
endmodule

// File: tb/tb_mmu_mem_arbiter.sv
// tb_mmu_mem_arbiter: table vectors, directed corner sequences and random traffic
// checked against a queue-based model of the arbiter.
module tb_mmu_mem_arbiter;
   logic clk = 1'b0, rst = 1'b1, flush = 1'b0, perr;
   mmu_mem_arbiter_if bus();
   mmu_mem_arbiter #(.P_DEPTH(16), .P_DEPTH_N(4)) dut (
      .iCLOCK(clk), .iRESET(rst), .iFLUSH(flush), .oPROTOCOL_ERR(perr), .bus(bus.slave)
   );
   always #5 clk = ~clk;
   int pass_n = 0, tot_n = 0;
   bit q[$];
   bit last_m, if_v, dt_v, err_m;
   logic [63:0] if_d, dt_d;
   typedef struct {
      bit ir, dr, rs;
      logic [63:0] rd;
      bit emr;
      logic [31:0] ea;
      bit eiv, edv;
      logic [63:0] ed;
   } vec_t;
   vec_t tbl [9];
   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      tot_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask
   task automatic mreset();
      q.delete();
      last_m = 1'b1;
      if_v = 0; dt_v = 0; err_m = 0;
      if_d = '0; dt_d = '0;
   endtask
   task automatic idle();
      bus.iIF_REQ = 0; bus.iIF_ORDER = 2'd1; bus.iIF_RW = 0; bus.iIF_ADDR = 32'h10; bus.iIF_DATA = 32'hA;
      bus.iDT_REQ = 0; bus.iDT_ORDER = 2'd2; bus.iDT_RW = 0; bus.iDT_ADDR = 32'h20; bus.iDT_DATA = 32'hB;
      bus.iIF_LOCK = 0; bus.iDT_LOCK = 0; bus.iMEMORY_LOCK = 0; bus.iMEMORY_REQ = 0; bus.iMEMORY_DATA = '0;
      flush = 0;
   endtask
   task automatic do_reset();
      rst = 1;
      idle();
      mreset();
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 0;
   endtask
   // One clock: check combinational outputs, advance the model, check registered outputs.
   task automatic step();
      bit g, mr, ml, il, dl, popped, owner;
      #1;
      g  = (bus.iIF_REQ && bus.iDT_REQ) ? !last_m : bus.iDT_REQ;
      mr = (bus.iIF_REQ || bus.iDT_REQ) && !flush && q.size() < 16;
      ml = q.size() != 0 && (q[0] ? bus.iDT_LOCK : bus.iIF_LOCK);
      il = !(bus.iIF_REQ && !g) || bus.iMEMORY_LOCK || q.size() == 16 || flush;
      dl = !(bus.iDT_REQ && g) || bus.iMEMORY_LOCK || q.size() == 16 || flush;
      chk("mem_req", bus.oMEMORY_REQ, mr);
      chk("mem_lock", bus.oMEMORY_LOCK, ml);
      chk("if_lock", bus.oIF_LOCK, il);
      chk("dt_lock", bus.oDT_LOCK, dl);
      if (mr) chk("mem_fields", {bus.oMEMORY_ORDER, bus.oMEMORY_RW, bus.oMEMORY_ADDR, bus.oMEMORY_DATA},
                  g ? {bus.iDT_ORDER, bus.iDT_RW, bus.iDT_ADDR, bus.iDT_DATA}
                    : {bus.iIF_ORDER, bus.iIF_RW, bus.iIF_ADDR, bus.iIF_DATA});
      @(posedge clk);
      if (flush) begin
         q.delete();
         if_v = 0; dt_v = 0; if_d = '0; dt_d = '0;
      end else begin
         popped = 0; owner = 0;
         if (bus.iMEMORY_REQ && !ml) begin
            if (q.size() == 0) err_m = 1;
            else begin owner = q.pop_front(); popped = 1; end
         end
         if (!bus.iIF_LOCK) begin if_v = popped && !owner; if (if_v) if_d = bus.iMEMORY_DATA; end
         if (!bus.iDT_LOCK) begin dt_v = popped && owner;  if (dt_v) dt_d = bus.iMEMORY_DATA; end
         if (mr && !bus.iMEMORY_LOCK) begin
            last_m = g;
            if (!(g ? bus.iDT_RW : bus.iIF_RW)) q.push_back(g);
         end
      end
      #1;
      chk("if_valid", bus.oIF_REQ, if_v);
      chk("dt_valid", bus.oDT_REQ, dt_v);
      chk("if_data", bus.oIF_DATA, if_d);
      chk("dt_data", bus.oDT_DATA, dt_d);
      chk("proto_err", perr, err_m);
      @(negedge clk);
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end
   initial begin
      tbl[0] = '{1, 1, 0, 64'h0, 1, 32'h10, 0, 0, 64'h0};
      tbl[1] = '{1, 1, 0, 64'h0, 1, 32'h20, 0, 0, 64'h0};
      tbl[2] = '{1, 1, 0, 64'h0, 1, 32'h10, 0, 0, 64'h0};
      tbl[3] = '{1, 1, 0, 64'h0, 1, 32'h20, 0, 0, 64'h0};
      tbl[4] = '{0, 0, 1, 64'h1, 0, 32'h0,  1, 0, 64'h1};
      tbl[5] = '{0, 0, 1, 64'h2, 0, 32'h0,  0, 1, 64'h2};
      tbl[6] = '{0, 0, 1, 64'h3, 0, 32'h0,  1, 0, 64'h3};
      tbl[7] = '{0, 0, 1, 64'h4, 0, 32'h0,  0, 1, 64'h4};
      tbl[8] = '{0, 0, 0, 64'h0, 0, 32'h0,  0, 0, 64'h0};
      idle();
      mreset();
      #1;
      chk("rst_if_valid", bus.oIF_REQ, 0);
      chk("rst_dt_data", bus.oDT_DATA, 0);
      chk("rst_err", perr, 0);
      chk("rst_mem_lock", bus.oMEMORY_LOCK, 0);
      do_reset();
      // alternating grants and in-order response routing
      for (int i = 0; i < 9; i++) begin
         bus.iIF_REQ = tbl[i].ir; bus.iDT_REQ = tbl[i].dr;
         bus.iMEMORY_REQ = tbl[i].rs; bus.iMEMORY_DATA = tbl[i].rd;
         #1;
         chk("tbl_mreq", bus.oMEMORY_REQ, tbl[i].emr);
         if (tbl[i].emr) chk("tbl_addr", bus.oMEMORY_ADDR, tbl[i].ea);
         step();
         chk("tbl_if_valid", bus.oIF_REQ, tbl[i].eiv);
         chk("tbl_dt_valid", bus.oDT_REQ, tbl[i].edv);
         if (tbl[i].eiv) chk("tbl_if_data", bus.oIF_DATA, tbl[i].ed);
         if (tbl[i].edv) chk("tbl_dt_data", bus.oDT_DATA, tbl[i].ed);
      end
      // queue full back-pressure
      do_reset();
      bus.iIF_REQ = 1;
      repeat (16) step();
      bus.iDT_REQ = 1;
      #1;
      chk("full_mreq", bus.oMEMORY_REQ, 0);
      chk("full_if_lock", bus.oIF_LOCK, 1);
      chk("full_dt_lock", bus.oDT_LOCK, 1);
      bus.iDT_REQ = 0;
      bus.iMEMORY_REQ = 1; bus.iMEMORY_DATA = 64'h99;
      step();
      bus.iMEMORY_REQ = 0;
      #1;
      chk("refill_mreq", bus.oMEMORY_REQ, 1);
      chk("refill_if_lock", bus.oIF_LOCK, 0);
      step();
      // write is forwarded but produces no response
      do_reset();
      bus.iDT_REQ = 1; bus.iDT_RW = 1; bus.iDT_ADDR = 32'h100; bus.iDT_DATA = 32'hDEADBEEF;
      #1;
      chk("wr_fields", {bus.oMEMORY_RW, bus.oMEMORY_ADDR, bus.oMEMORY_DATA}, {1'b1, 32'h100, 32'hDEADBEEF});
      step();
      bus.iDT_REQ = 0; bus.iIF_REQ = 1;
      step();
      bus.iIF_REQ = 0; bus.iMEMORY_REQ = 1; bus.iMEMORY_DATA = 64'h55;
      step();
      chk("wr_if_rsp", {bus.oIF_REQ, bus.oDT_REQ, bus.oIF_DATA}, {2'b10, 64'h55});
      step();
      chk("wr_no_dt_rsp", {bus.oDT_REQ, perr}, 2'b01);
      // response held back by DT lock
      do_reset();
      bus.iDT_REQ = 1;
      step();
      bus.iDT_REQ = 0; bus.iDT_LOCK = 1; bus.iMEMORY_REQ = 1; bus.iMEMORY_DATA = 64'h77;
      #1;
      chk("lock_mem_lock", bus.oMEMORY_LOCK, 1);
      step();
      step();
      chk("lock_dt_held", {bus.oDT_REQ, bus.oDT_DATA}, 65'h0);
      bus.iDT_LOCK = 0;
      step();
      chk("lock_dt_rsp", {bus.oDT_REQ, bus.oDT_DATA}, {1'b1, 64'h77});
      bus.iMEMORY_REQ = 0;
      step();
      // flush with outstanding tags, then a stray response
      do_reset();
      bus.iIF_REQ = 1;
      repeat (4) step();
      bus.iIF_REQ = 0; bus.iMEMORY_REQ = 1; bus.iMEMORY_DATA = 64'h31;
      step();
      bus.iMEMORY_REQ = 0; flush = 1;
      step();
      chk("flush_valid", {bus.oIF_REQ, bus.oIF_DATA}, 65'h0);
      flush = 0; bus.iMEMORY_REQ = 1;
      step();
      chk("flush_err", {perr, bus.oIF_REQ}, 2'b10);
      bus.iMEMORY_REQ = 0; flush = 1;
      step();
      chk("err_sticky", perr, 1);
      flush = 0;
      // asynchronous reset mid-traffic
      do_reset();
      bus.iMEMORY_REQ = 1;
      step();
      bus.iMEMORY_REQ = 0; bus.iIF_REQ = 1;
      repeat (6) step();
      bus.iIF_REQ = 0; bus.iMEMORY_REQ = 1; bus.iMEMORY_DATA = 64'h42;
      step();
      bus.iMEMORY_REQ = 0;
      #1;
      rst = 1;
      #1;
      chk("arst_outputs", {bus.oIF_REQ, bus.oIF_DATA, perr, bus.oMEMORY_LOCK}, 67'h0);
      mreset();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
      bus.iIF_REQ = 1; bus.iDT_REQ = 1;
      #1;
      chk("arst_if_wins", bus.oMEMORY_ADDR, 32'h10);
      step();
      // random traffic against the model
      do_reset();
      for (int i = 0; i < 600; i++) begin
         bus.iIF_REQ = $urandom_range(3) != 0;
         bus.iDT_REQ = $urandom_range(3) != 0;
         bus.iIF_RW = $urandom_range(3) == 0;
         bus.iDT_RW = $urandom_range(3) == 0;
         bus.iIF_ORDER = 2'($urandom); bus.iDT_ORDER = 2'($urandom);
         bus.iIF_ADDR = $urandom; bus.iDT_ADDR = $urandom;
         bus.iIF_DATA = $urandom; bus.iDT_DATA = $urandom;
         bus.iIF_LOCK = $urandom_range(3) == 0;
         bus.iDT_LOCK = $urandom_range(3) == 0;
         bus.iMEMORY_LOCK = $urandom_range(3) == 0;
         bus.iMEMORY_REQ = $urandom_range(1) == 1;
         bus.iMEMORY_DATA = {$urandom, $urandom};
         flush = $urandom_range(63) == 0;
         step();
      end
      $display("%0d/%0d checks passed", pass_n, tot_n);
      $finish;
   end
endmodule
